// File: rtl/vdc_bus_master.sv
// vdc_bus_master: bus initiator for the HuC6270 CPU port.
// Turns one 16-bit register request into the byte-wise CS_n/RD_n/WR_n/A
// access sequence and collects read data. Every bus output is registered:
// the output logic computes the values for the state being entered, and
// those values are loaded on the same edge that loads the state.

module vdc_bus_master #(
    parameter int STROBE_CYC = 1,      // RD_n/WR_n low time per byte, 1..15
    parameter bit CACHE_ADDR = 1'b1    // skip the address write on a register hit
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_kind,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        CS_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic [1:0]  A,
    output logic [7:0]  DO,
    input  logic [7:0]  DI,
    input  logic        BUSY_n
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    // Request kinds: 0 register write, 1 register read, 2 status read, 3 address only
    localparam logic [1:0] KIND_WR   = 2'd0;
    localparam logic [1:0] KIND_STAT = 2'd2;
    localparam logic [1:0] KIND_ADDR = 2'd3;

    // Byte steps within one request
    localparam logic [1:0] STEP_ADDR = 2'd0;
    localparam logic [1:0] STEP_LSB  = 2'd1;
    localparam logic [1:0] STEP_MSB  = 2'd2;
    localparam logic [1:0] STEP_STAT = 2'd3;

    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);

    // Direction of a byte: address bytes always write, status always reads,
    // data bytes follow the request kind.
    function automatic logic step_is_write(input logic [1:0] kind, input logic [1:0] step);
        logic w;
        case (step)
            STEP_ADDR: w = 1'b1;
            STEP_LSB,
            STEP_MSB:  w = (kind == KIND_WR);
            STEP_STAT: w = 1'b0;
            default:   w = 1'b0;
        endcase
        return w;
    endfunction

    // Port select driven for a byte step
    function automatic logic [1:0] step_port(input logic [1:0] step);
        logic [1:0] p;
        case (step)
            STEP_ADDR: p = 2'd0;
            STEP_LSB:  p = 2'd2;
            STEP_MSB:  p = 2'd3;
            STEP_STAT: p = 2'd0;
            default:   p = 2'd0;
        endcase
        return p;
    endfunction

    // Byte placed on DO for a step; read bytes drive zero
    function automatic logic [7:0] step_byte(input logic [1:0]  kind,
                                             input logic [1:0]  step,
                                             input logic [4:0]  rnum,
                                             input logic [15:0] wdata);
        logic [7:0] b;
        case (step)
            STEP_ADDR: b = {3'b000, rnum};
            STEP_LSB:  b = (kind == KIND_WR) ? wdata[7:0]  : 8'h00;
            STEP_MSB:  b = (kind == KIND_WR) ? wdata[15:8] : 8'h00;
            STEP_STAT: b = 8'h00;
            default:   b = 8'h00;
        endcase
        return b;
    endfunction

    // True when the step is the final byte of its request
    function automatic logic step_is_last(input logic [1:0] kind, input logic [1:0] step);
        logic l;
        case (step)
            STEP_ADDR: l = (kind == KIND_ADDR);
            STEP_LSB:  l = 1'b0;
            STEP_MSB:  l = 1'b1;
            STEP_STAT: l = 1'b1;
            default:   l = 1'b1;
        endcase
        return l;
    endfunction

    // First byte of a request; a cache hit jumps straight to the data LSB
    function automatic logic [1:0] first_step(input logic [1:0] kind, input logic hit);
        logic [1:0] s;
        case (kind)
            KIND_STAT: s = STEP_STAT;
            KIND_ADDR: s = STEP_ADDR;
            default:   s = hit ? STEP_LSB : STEP_ADDR;
        endcase
        return s;
    endfunction

    // Step following a non-final byte
    function automatic logic [1:0] next_step(input logic [1:0] step);
        logic [1:0] s;
        case (step)
            STEP_ADDR: s = STEP_LSB;
            STEP_LSB:  s = STEP_MSB;
            default:   s = step;
        endcase
        return s;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  step_r;
    logic [1:0]  step_s;
    logic [1:0]  kind_r;
    logic [4:0]  reg_r;
    logic [15:0] wdata_r;
    logic [15:0] acc_r;
    logic [3:0]  cnt_r;
    logic [4:0]  last_reg_r;
    logic        last_valid_r;

    logic        accept_s;
    logic        cache_hit_s;
    logic        capture_s;
    logic        done_s;
    logic [1:0]  kind_sel_s;
    logic [4:0]  reg_sel_s;
    logic [15:0] wdata_sel_s;
    logic        cs_s;
    logic        rd_s;
    logic        wr_s;
    logic [1:0]  a_s;
    logic [7:0]  do_s;

    assign accept_s    = (state_r == ST_IDLE) && req_valid;
    assign cache_hit_s = CACHE_ADDR && last_valid_r && (last_reg_r == req_reg);
    assign capture_s   = (state_r == ST_STROBE) && (cnt_r == 4'd0) && !step_is_write(kind_r, step_r);
    assign done_s      = (state_r == ST_GAP) && step_is_last(kind_r, step_r);

    // State and current byte step register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            step_r  <= STEP_ADDR;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
        end
    end

    // Next-state logic: byte phases and progression through the request's bytes
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = ST_SETUP;
                    step_s  = first_step(req_kind, cache_hit_s);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (BUSY_n) begin
                    state_s = ST_STROBE;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (cnt_r == STROBE_LAST) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                state_s = ST_GAP;
            end
            ST_GAP: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SETUP;
                    step_s  = next_step(step_r);
                end
            end
            default: begin
                state_s = ST_IDLE;
                step_s  = STEP_ADDR;
            end
        endcase
    end

    // Output logic: bus levels for the state being entered (A/DO hold outside SETUP)
    always_comb begin
        kind_sel_s  = accept_s ? req_kind  : kind_r;
        reg_sel_s   = accept_s ? req_reg   : reg_r;
        wdata_sel_s = accept_s ? req_wdata : wdata_r;
        cs_s = 1'b1;
        rd_s = 1'b1;
        wr_s = 1'b1;
        a_s  = A;
        do_s = DO;
        case (state_s)
            ST_SETUP: begin
                cs_s = 1'b0;
                a_s  = step_port(step_s);
                do_s = step_byte(kind_sel_s, step_s, reg_sel_s, wdata_sel_s);
            end
            ST_STROBE: begin
                cs_s = 1'b0;
                if (step_is_write(kind_sel_s, step_s)) begin
                    wr_s = 1'b0;
                end else begin
                    rd_s = 1'b0;
                end
            end
            ST_HOLD: begin
                cs_s = 1'b0;
            end
            ST_IDLE,
            ST_GAP: begin
                cs_s = 1'b1;
            end
            default: begin
                cs_s = 1'b1;
            end
        endcase
    end

    // Bus output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            CS_n      <= 1'b1;
            RD_n      <= 1'b1;
            WR_n      <= 1'b1;
            A         <= 2'd0;
            DO        <= 8'h00;
            req_ready <= 1'b1;
        end else begin
            CS_n      <= cs_s;
            RD_n      <= rd_s;
            WR_n      <= wr_s;
            A         <= a_s;
            DO        <= do_s;
            req_ready <= (state_s == ST_IDLE);
        end
    end

    // Request capture at accept and read-byte assembly on the first strobe cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kind_r  <= 2'd0;
            reg_r   <= 5'd0;
            wdata_r <= 16'h0000;
            acc_r   <= 16'h0000;
        end else if (accept_s) begin
            kind_r  <= req_kind;
            reg_r   <= req_reg;
            wdata_r <= req_wdata;
            acc_r   <= 16'h0000;
        end else if (capture_s) begin
            case (step_r)
                STEP_LSB:  acc_r[7:0]  <= DI;
                STEP_MSB:  acc_r[15:8] <= DI;
                STEP_STAT: acc_r       <= {8'h00, DI};
                default:   acc_r       <= acc_r;
            endcase
        end else begin
            acc_r <= acc_r;
        end
    end

    // Strobe-length counter, running only while a strobe is low
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= 4'd0;
        end else if (state_r == ST_STROBE) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= 4'd0;
        end
    end

    // Address cache: remembers the register once its address byte has finished HOLD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_reg_r   <= 5'd0;
            last_valid_r <= 1'b0;
        end else if ((state_r == ST_HOLD) && (step_r == STEP_ADDR)) begin
            last_reg_r   <= reg_r;
            last_valid_r <= 1'b1;
        end else begin
            last_reg_r   <= last_reg_r;
            last_valid_r <= last_valid_r;
        end
    end

    // Response: one-cycle pulse on the first IDLE cycle, read data held until the next one
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
        end else if (done_s) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= acc_r;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= rsp_rdata;
        end
    end

endmodule

// File: tb/tb_vdc_bus_master.sv
// Testbench for vdc_bus_master. Three instances cover the parameter corners:
//   d0: STROBE_CYC=1, CACHE_ADDR=1   d1: STROBE_CYC=1, CACHE_ADDR=0
//   d2: STROBE_CYC=3, CACHE_ADDR=1
// A VDC slave model answers reads (DI valid only in the first RD_n-low cycle),
// inserts BUSY_n wait states and logs every byte access. A request-level
// reference model predicts the byte list, read data and latency.
// Latency is the index of the rising edge that samples rsp_valid=1, with the
// accept edge counted as 0.

module tb_vdc_bus_master;

    localparam int ND     = 3;
    localparam int BUDGET = 200;

    typedef struct {
        logic [1:0] a;
        logic [7:0] dout;
        int         wr_len;
        int         rd_len;
        bit         stable;
    } byte_rec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [ND];
    logic        req_ready [ND];
    logic [1:0]  req_kind  [ND];
    logic [4:0]  req_reg   [ND];
    logic [15:0] req_wdata [ND];
    logic        rsp_valid [ND];
    logic [15:0] rsp_rdata [ND];
    logic        cs_n      [ND];
    logic        rd_n      [ND];
    logic        wr_n      [ND];
    logic [1:0]  a         [ND];
    logic [7:0]  dout      [ND];
    logic [7:0]  di        [ND];
    logic        busy_n    [ND];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int stray_cnt = 0;

    // reference model state
    logic [15:0] ref_regs [ND][32];
    logic [4:0]  ref_lr   [ND];
    bit          ref_lv   [ND];
    logic [7:0]  status_v [ND];

    // slave model state
    logic [15:0] s_regs [ND][32];
    logic [4:0]  s_addr [ND];
    bit          m_open [ND];
    byte_rec_t   m_cur  [ND];
    int          m_busy [ND];
    byte_rec_t   mon_q[$];
    int          busy_q[$];

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < ND; g++) begin : g_dut
            vdc_bus_master #(
                .STROBE_CYC(g == 2 ? 3 : 1),
                .CACHE_ADDR(g == 1 ? 1'b0 : 1'b1)
            ) u_dut (
                .clock    (clock),
                .reset_n  (reset_n),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_kind (req_kind[g]),
                .req_reg  (req_reg[g]),
                .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_rdata(rsp_rdata[g]),
                .CS_n     (cs_n[g]),
                .RD_n     (rd_n[g]),
                .WR_n     (wr_n[g]),
                .A        (a[g]),
                .DO       (dout[g]),
                .DI       (di[g]),
                .BUSY_n   (busy_n[g])
            );
        end
    endgenerate

    function automatic int s_cyc(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic bit cache_on(input int d);
        return (d != 1);
    endfunction

    function automatic logic [7:0] read_val(input int d, input logic [1:0] port);
        logic [15:0] w;
        w = s_regs[d][s_addr[d]];
        if (port == 2'd0) return status_v[d];
        else if (port == 2'd2) return w[7:0];
        else return w[15:8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // VDC slave: logs bytes, answers reads, inserts wait states
    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (!reset_n) begin
                m_open[d] = 1'b0;
                busy_n[d] = 1'b1;
                di[d]     = 8'hEE;
            end else if (!cs_n[d]) begin
                if (!m_open[d]) begin
                    m_open[d]        = 1'b1;
                    m_cur[d].a       = a[d];
                    m_cur[d].dout    = dout[d];
                    m_cur[d].wr_len  = 0;
                    m_cur[d].rd_len  = 0;
                    m_cur[d].stable  = 1'b1;
                    if (busy_q.size() > 0) m_busy[d] = busy_q.pop_front();
                    else m_busy[d] = 0;
                    busy_n[d] = (m_busy[d] == 0);
                end else if (rd_n[d] && wr_n[d] && m_cur[d].wr_len == 0 &&
                             m_cur[d].rd_len == 0 && m_busy[d] > 0) begin
                    m_busy[d] = m_busy[d] - 1;
                    busy_n[d] = (m_busy[d] == 0);
                end
                if (a[d] !== m_cur[d].a || dout[d] !== m_cur[d].dout || a[d] == 2'd1 ||
                    (!rd_n[d] && !wr_n[d]))
                    m_cur[d].stable = 1'b0;
                if (!wr_n[d]) m_cur[d].wr_len = m_cur[d].wr_len + 1;
                if (!rd_n[d]) begin
                    di[d] = (m_cur[d].rd_len == 0) ? read_val(d, a[d]) : 8'hEE;
                    m_cur[d].rd_len = m_cur[d].rd_len + 1;
                end else begin
                    di[d] = 8'hEE;
                end
                if (!rd_n[d] || !wr_n[d]) busy_n[d] = 1'($urandom_range(0, 1));
            end else begin
                if (m_open[d]) begin
                    if (m_cur[d].wr_len > 0) begin
                        if (m_cur[d].a == 2'd0) s_addr[d] = m_cur[d].dout[4:0];
                        else if (m_cur[d].a == 2'd2) s_regs[d][s_addr[d]][7:0] = m_cur[d].dout;
                        else if (m_cur[d].a == 2'd3) s_regs[d][s_addr[d]][15:8] = m_cur[d].dout;
                    end
                    mon_q.push_back(m_cur[d]);
                    m_open[d] = 1'b0;
                end
                if (!rd_n[d] || !wr_n[d]) stray_cnt++;
                busy_n[d] = 1'b1;
                di[d]     = 8'hEE;
            end
        end
    end

    // One request on instance d; busy_mode<0 gives random waits, else waits on the first byte only
    task automatic run_req(input int d, input logic [1:0] kind, input logic [4:0] rg,
                           input logic [15:0] wd, input int busy_mode);
        logic [1:0]  ea[$];
        bit          ew[$];
        logic [7:0]  ed[$];
        logic [15:0] erd;
        int          elat, n, ready_bad, busy_sum, b;
        bit          hit;
        byte_rec_t   r;
        erd = 16'h0000;
        hit = cache_on(d) && ref_lv[d] && (ref_lr[d] == rg);
        case (kind)
            2'd0, 2'd1: begin
                if (!hit) begin
                    ea.push_back(2'd0); ew.push_back(1'b1); ed.push_back({3'b000, rg});
                end
                ea.push_back(2'd2); ew.push_back(kind == 2'd0); ed.push_back(wd[7:0]);
                ea.push_back(2'd3); ew.push_back(kind == 2'd0); ed.push_back(wd[15:8]);
                if (kind == 2'd0) ref_regs[d][rg] = wd;
                else erd = ref_regs[d][rg];
                ref_lr[d] = rg;
                ref_lv[d] = 1'b1;
            end
            2'd2: begin
                ea.push_back(2'd0); ew.push_back(1'b0); ed.push_back(8'h00);
                erd = {8'h00, status_v[d]};
            end
            default: begin
                ea.push_back(2'd0); ew.push_back(1'b1); ed.push_back({3'b000, rg});
                ref_lr[d] = rg;
                ref_lv[d] = 1'b1;
            end
        endcase
        busy_sum = 0;
        busy_q.delete();
        for (int i = 0; i < ea.size(); i++) begin
            b = (busy_mode < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? busy_mode : 0);
            busy_q.push_back(b);
            busy_sum += b;
        end
        elat = 1 + ea.size() * (3 + s_cyc(d)) + busy_sum;
        mon_q.delete();

        @(negedge clock);
        chk("ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_kind[d]  = kind;
        req_reg[d]   = rg;
        req_wdata[d] = wd;
        @(posedge clock);
        #1;
        req_valid[d] = 1'b0;
        req_kind[d]  = 2'($urandom);
        req_reg[d]   = 5'($urandom);
        req_wdata[d] = 16'($urandom);

        n = 0;
        ready_bad = 0;
        while (n < BUDGET) begin
            @(negedge clock);
            n++;
            if (rsp_valid[d]) break;
            if (req_ready[d]) ready_bad++;
        end
        chk("latency", 32'(n), 32'(elat));
        chk("ready_busy", 32'(ready_bad), 32'd0);
        chk("ready_done", 32'(req_ready[d]), 32'd1);
        if (kind == 2'd1 || kind == 2'd2) chk("rdata", 32'(rsp_rdata[d]), 32'(erd));
        chk("nbytes", 32'(mon_q.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < mon_q.size(); i++) begin
            r = mon_q[i];
            chk("byte_a", 32'(r.a), 32'(ea[i]));
            chk("byte_dir", 32'(r.wr_len > 0), 32'(ew[i]));
            chk("strobe_len", 32'(r.wr_len + r.rd_len), 32'(s_cyc(d)));
            chk("byte_stable", 32'(r.stable), 32'd1);
            if (ew[i]) chk("byte_do", 32'(r.dout), 32'(ed[i]));
        end
        @(negedge clock);
        chk("rsp_pulse", 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        int n, seen;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            req_kind[d]  = 2'd0;
            req_reg[d]   = 5'd0;
            req_wdata[d] = 16'h0000;
            ref_lv[d]    = 1'b0;
            ref_lr[d]    = 5'd0;
            s_addr[d]    = 5'd0;
            status_v[d]  = 8'h00;
            m_open[d]    = 1'b0;
            m_busy[d]    = 0;
            busy_n[d]    = 1'b1;
            di[d]        = 8'hEE;
            for (int r = 0; r < 32; r++) begin
                ref_regs[d][r] = 16'(r * 257 + d * 4099);
                s_regs[d][r]   = 16'(r * 257 + d * 4099);
            end
        end

        // reset state
        repeat (3) @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            chk("rst_cs", 32'(cs_n[d]), 32'd1);
            chk("rst_rd", 32'(rd_n[d]), 32'd1);
            chk("rst_wr", 32'(wr_n[d]), 32'd1);
            chk("rst_a", 32'(a[d]), 32'd0);
            chk("rst_do", 32'(dout[d]), 32'd0);
            chk("rst_ready", 32'(req_ready[d]), 32'd1);
            chk("rst_rsp", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", 32'(rsp_rdata[d]), 32'd0);
        end
        reset_n = 1'b1;

        // full write, then cache hit; no cache on d1
        run_req(0, 2'd0, 5'd5, 16'hA55A, 0);
        run_req(0, 2'd0, 5'd5, 16'h1234, 0);
        run_req(1, 2'd0, 5'd5, 16'hA55A, 0);
        run_req(1, 2'd0, 5'd5, 16'h1234, 0);

        // read back with a 3-cycle strobe
        run_req(2, 2'd0, 5'd2, 16'h1234, 0);
        run_req(2, 2'd1, 5'd2, 16'h0000, 0);

        // status read leaves the cache alone
        status_v[0] = 8'h20;
        run_req(0, 2'd2, 5'd0, 16'h0000, 0);
        run_req(0, 2'd0, 5'd5, 16'hBEEF, 0);

        // 4 busy cycles during the first SETUP
        run_req(0, 2'd0, 5'd7, 16'h55AA, 4);

        // reset in the middle of the LSB write strobe
        mon_q.delete();
        busy_q.delete();
        @(negedge clock);
        req_valid[0] = 1'b1;
        req_kind[0]  = 2'd0;
        req_reg[0]   = 5'd5;
        req_wdata[0] = 16'hC3C3;
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        seen = 0;
        n = 0;
        while (n < BUDGET && seen == 0) begin
            @(negedge clock);
            n++;
            if (!wr_n[0] && a[0] == 2'd2) seen = 1;
        end
        chk("lsb_strobe_seen", 32'(seen), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_cs", 32'(cs_n[0]), 32'd1);
        chk("arst_wr", 32'(wr_n[0]), 32'd1);
        for (int d = 0; d < ND; d++) ref_lv[d] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (rsp_valid[0]) seen++;
        end
        chk("arst_no_rsp", 32'(seen), 32'd0);
        run_req(0, 2'd0, 5'd5, 16'h0F0F, 0);

        // randomized traffic on every instance
        for (int d = 0; d < ND; d++) begin
            repeat (20) begin
                logic [1:0] k;
                k = 2'($urandom_range(0, 3));
                if (k == 2'd2) status_v[d] = 8'($urandom);
                run_req(d, k, 5'($urandom_range(0, 3)), 16'($urandom), -1);
            end
        end

        chk("stray_strobe", 32'(stray_cnt), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vdc_bus_master.md
# vdc_bus_master

Bus initiator for the HuC6270 CPU port: turns one 16-bit register request into the byte-wise CS_n/RD_n/WR_n/A access sequence the VDC control unit decodes, and collects read data. It sits between a CPU-side or test-harness command source and the VDC. It is the master-side counterpart of the VDC's edge-detecting slave port.

## Interface
Parameters:
- STROBE_CYC, 1: cycles RD_n/WR_n are held low per byte. Legal range is 1–15.
- CACHE_ADDR, 1: when 1, skip the address-register write if the requested register equals the last register written.

Ports (clock and reset first):
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
- req_kind  in  2  request type:
  - 0 = register write
  - 1 = register read
  - 2 = status read
  - 3 = address-only write
- req_reg  in  5  VDC register number.
- req_wdata  in  16  write data; LSB is sent first.
- rsp_valid  out  1  one-cycle pulse when a request completes (all kinds).
- rsp_rdata  out  16  read result; held until the next response.
- CS_n, RD_n, WR_n  out  1 each  VDC strobes, active-low.
- A  out  2  VDC port select:
  - 0 = status/address
  - 2 = data LSB
  - 3 = data MSB
  - 1 is never driven.
- DO  out  8  byte to VDC DI.
- DI  in  8  byte from VDC DO; valid only in the first RD_n-low cycle.
- BUSY_n  in  1  VDC busy, active-low.

## Operation
- All req_* fields are captured at accept; later changes are ignored.
- Byte sequence per kind:
  - kind 0: [addr write A=0, DO=req_reg zero-extended] → write A=2 DO=wdata[7:0] → write A=3 DO=wdata[15:8].
  - kind 1: [addr write] → read A=2 into rdata[7:0] → read A=3 into rdata[15:8].
  - kind 2: one read at A=0; rsp_rdata = {8'h00, status}. The address cache is untouched.
  - kind 3: addr write only. It is never skipped.
- Address cache: last_reg (5b) and last_valid.
  - Updated when an address byte completes its HOLD phase.
  - The bracketed addr write is skipped when CACHE_ADDR=1 && last_valid && last_reg==req_reg.
  - Reset clears last_valid.
- Byte access FSM phases: SETUP → STROBE → HOLD → GAP, then either the next byte's SETUP or IDLE.
  - SETUP: CS_n=0, A and DO driven, strobes high. Stays in SETUP while BUSY_n=0; advances on the first cycle BUSY_n=1.
  - STROBE: RD_n or WR_n =0 for exactly STROBE_CYC cycles. BUSY_n is ignored.
  - Read data: DI is captured at the end of the first STROBE cycle.
  - HOLD: strobe high, CS_n, A and DO unchanged (1 cycle).
  - GAP: CS_n=1, strobes high (1 cycle). A and DO keep their last values.
- Completion: the first IDLE cycle after the final GAP has rsp_valid=1 and req_ready=1. A new request may be accepted in that same cycle.
- CS_n is never low while both strobes are low, and RD_n and WR_n are never low together.

## Timing
- Reset values (asserted immediately, asynchronously): state IDLE, CS_n=RD_n=WR_n=1, A=0, DO=0, req_ready=1, rsp_valid=0, rsp_rdata=0, last_valid=0.
- Cycles per byte = 3 + STROBE_CYC + busy-wait cycles.
- Accept-to-rsp_valid latency with STROBE_CYC=1 and no busy wait (accept edge = cycle 0):
  - kind 0/1 with addr write: rsp_valid in cycle 13.
  - kind 0/1 on a cache hit: cycle 9.
  - kind 2/3: cycle 5.
- Reset mid-access: the bus returns to idle levels immediately. No rsp_valid is issued, and the cache is invalid.

## Test plan
- Reset, then kind 0 reg=5 wdata=16'hA55A → byte sequence (A=0, DO=05), (A=2, DO=5A), (A=3, DO=A5); each WR_n low exactly 1 cycle; rsp_valid in cycle 13.
- Repeat kind 0 reg=5 wdata=16'h1234 → no A=0 access; 2 bytes written; rsp_valid in cycle 9. With CACHE_ADDR=0 → 3 bytes, cycle 13.
- kind 1 reg=2, VDC model returns 8'h34 then 8'h12 only in the first RD_n-low cycle, with STROBE_CYC=3 → rsp_rdata=16'h1234.
- kind 2, status 8'h20 → single read at A=0; rsp_rdata=16'h0020; a following kind 0 reg=5 still skips the addr write.
- BUSY_n held low for 4 cycles during the first SETUP → strobe delayed 4 cycles; latency 17; byte values unchanged.
- reset_n asserted mid-STROBE of the LSB write → CS_n/WR_n high in the same cycle; no rsp_valid; the next kind 0 reg=5 performs the addr write.
